// File: rtl/dp_ram_arb_pkg.sv
// Shared constants and helpers for the dp_ram arbiter slice.
package dp_ram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  // Grant-to-rd_valid latency: rdaddress register plus the RAM output register.
  localparam int RD_LAT         = 2;

  // Ceiling log2 with a floor of 1 so single-requester ports still get a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dp_ram_arbiter_if.sv
// Requester and RAM-side bus of the dp_ram arbiter.
// slave: arbiter side. master: requesters plus the attached dp_ram.
interface dp_ram_arbiter_if
  import dp_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4,
  parameter int ID_W       = 2
);

  logic [NUM_WR-1:0]            wr_req;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]            wr_gnt;

  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_gnt;
  logic                         rd_valid;
  logic [ID_W-1:0]              rd_id;
  logic [DATA_WIDTH-1:0]        rd_data;

  logic                         ram_wren;
  logic [ADDR_WIDTH-1:0]        ram_wraddress;
  logic [DATA_WIDTH-1:0]        ram_data;
  logic [ADDR_WIDTH-1:0]        ram_rdaddress;
  logic [DATA_WIDTH-1:0]        ram_q;
  logic                         ram_aclr;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
           ram_wren, ram_wraddress, ram_data, ram_rdaddress, ram_aclr
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
           ram_wren, ram_wraddress, ram_data, ram_rdaddress, ram_aclr
  );

endinterface

// File: rtl/dp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts after the
// last winner. advance=0 suppresses grants and freezes the pointer.
module rr_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] idx,
  output logic                any
);

  localparam int PW = clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;

  // Scan ptr+1 .. ptr+N (mod N); the first asserted request wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (advance && !any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

  // Pointer parks on the last index at reset so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n)   ptr <= PW'(N - 1);
    else if (any) ptr <= idx;
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares one dp_ram between NUM_WR writers and NUM_RD readers.
// Independent round-robin per port, registered RAM drive, 2-cycle tagged
// read return. Optional macro WR_BYPASS_EN forwards same-cycle write data
// to a colliding read instead of returning the old word.
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 4,
  parameter int ID_W       = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dp_ram_arbiter_if.slave bus
);

  localparam int WPW    = clog2(NUM_WR);
  localparam int RPW    = clog2(NUM_RD);
  localparam int STAGES = RD_LAT;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_beat_t;

  // Unflattened requester buses.
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_unpack
    assign wa[g] = bus.wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[g] = bus.wr_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_unpack
    assign ra[g] = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [NUM_WR-1:0] wr_gnt;
  logic [NUM_RD-1:0] rd_gnt;
  logic [WPW-1:0]    wr_idx;
  logic [RPW-1:0]    rd_idx;
  logic              wr_any;
  logic              rd_any;

  // Grants are held off while reset is asserted.
  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (rst_n),
    .req     (bus.wr_req),
    .gnt     (wr_gnt),
    .idx     (wr_idx),
    .any     (wr_any)
  );

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (rst_n),
    .req     (bus.rd_req),
    .gnt     (rd_gnt),
    .idx     (rd_idx),
    .any     (rd_any)
  );

  assign bus.wr_gnt = wr_gnt;
  assign bus.rd_gnt = rd_gnt;

  // Write port: latch the winner's beat; wren follows the grant by one cycle.
  wr_beat_t wr_q;
  logic     wren_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wren_q <= 1'b0;
      wr_q   <= '0;
    end else begin
      wren_q <= wr_any;
      if (wr_any) begin
        wr_q.addr <= wa[wr_idx];
        wr_q.data <= wd[wr_idx];
      end
    end
  end

  assign bus.ram_wren      = wren_q;
  assign bus.ram_wraddress = wr_q.addr;
  assign bus.ram_data      = wr_q.data;

  // Read port: address register plus valid/tag shift registers matching the
  // RAM's output register, so tag and ram_q line up at stage STAGES.
  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1][ID_W-1:0] id_pipe;
  logic [ADDR_WIDTH-1:0]     rdaddr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      rdaddr_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_any};
      id_pipe  <= {id_pipe[STAGES-1:1], ID_W'(rd_idx)};
      if (rd_any) rdaddr_q <= ra[rd_idx];
    end
  end

  assign bus.ram_rdaddress = rdaddr_q;
  assign bus.rd_valid      = vld_pipe[STAGES];
  assign bus.rd_id         = id_pipe[STAGES];

  // RAM async clear mirrors reset one cycle late.
  logic aclr_q;

  always_ff @(posedge clk) begin
    aclr_q <= ~rst_n;
  end

  assign bus.ram_aclr = aclr_q;

`ifdef WR_BYPASS_EN
  // A read colliding with a same-cycle write would see the old word from the
  // RAM; carry the write data alongside the read and substitute it on return.
  logic                            hit;
  logic [STAGES:1]                 hit_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0] fwd_pipe;

  assign hit = wr_any && rd_any && (wa[wr_idx] == ra[rd_idx]);

  // Forwarding pipeline, same depth as the read tag pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_pipe <= '0;
      fwd_pipe <= '0;
    end else begin
      hit_pipe <= {hit_pipe[STAGES-1:1], hit};
      fwd_pipe <= {fwd_pipe[STAGES-1:1], wd[wr_idx]};
    end
  end

  assign bus.rd_data = hit_pipe[STAGES] ? fwd_pipe[STAGES] : bus.ram_q;
`else
  assign bus.rd_data = bus.ram_q;
`endif

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a registered dp_ram model.
module tb_dp_ram_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  dp_ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_WR(2), .NUM_RD(4), .ID_W(2)) bus ();

  dp_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_WR(2), .NUM_RD(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dp_ram model: registered write, registered read output (old data on collision).
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_rdaddress];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.rd_req   = 4'b1111;
    bus.wr_req   = 2'b11;
    bus.rd_addr  = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    for (int c = 0; c < 3; c++) begin
      next_cyc(); #1;
      n_cmp++; if (bus.rd_gnt !== 4'b0000) begin n_err++; $display("FAIL reset_rd_gnt c=%0d got %b want 0000", c, bus.rd_gnt); end
      n_cmp++; if (bus.wr_gnt !== 2'b00) begin n_err++; $display("FAIL reset_wr_gnt c=%0d got %b want 00", c, bus.wr_gnt); end
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid c=%0d got %b want 0", c, bus.rd_valid); end
      n_cmp++; if (bus.ram_aclr !== 1'b1) begin n_err++; $display("FAIL reset_aclr c=%0d got %b want 1", c, bus.ram_aclr); end
      n_cmp++; if (bus.ram_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren c=%0d got %b want 0", c, bus.ram_wren); end
      n_cmp++; if (bus.rd_id !== 2'd0) begin n_err++; $display("FAIL reset_rd_id c=%0d got %0d want 0", c, bus.rd_id); end
    end
    next_cyc();
    rst_n      = 1'b1;
    bus.wr_req = 2'b00;
    #1;
    n_cmp++; if (bus.rd_gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got %b want 0001", bus.rd_gnt); end
    next_cyc();
    bus.rd_req = 4'b0000;
    #1;
    n_cmp++; if (bus.ram_aclr !== 1'b0) begin n_err++; $display("FAIL reset_aclr_release got %b want 0", bus.ram_aclr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic       exp_v;
    next_cyc();
    rst_n      = 1'b0;
    bus.rd_req = 4'b0000;
    for (int c = 0; c < 11; c++) begin
      next_cyc();
      rst_n      = 1'b1;
      bus.rd_req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_g = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      exp_v = (c >= 2) && (c < 10);
      n_cmp++; if (bus.rd_gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt c=%0d got %b want %b", c, bus.rd_gnt, exp_g); end
      n_cmp++; if (bus.rd_valid !== exp_v) begin n_err++; $display("FAIL rr_valid c=%0d got %b want %b", c, bus.rd_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.rd_id !== 2'((c - 2) % 4)) begin n_err++; $display("FAIL rr_id c=%0d got %0d want %0d", c, bus.rd_id, (c - 2) % 4); end
      end
    end
  endtask

  task automatic test_write_read();
    next_cyc();
    bus.wr_req        = 2'b10;
    bus.wr_addr[6 +: 6] = 6'h10;
    bus.wr_data[8 +: 8] = 8'hA5;
    #1;
    n_cmp++; if (bus.wr_gnt !== 2'b10) begin n_err++; $display("FAIL wr_gnt got %b want 10", bus.wr_gnt); end
    next_cyc();
    bus.wr_req = 2'b00;
    #1;
    n_cmp++; if (bus.ram_wren !== 1'b1) begin n_err++; $display("FAIL wr_wren got %b want 1", bus.ram_wren); end
    n_cmp++; if (bus.ram_wraddress !== 6'h10) begin n_err++; $display("FAIL wr_addr got %h want 10", bus.ram_wraddress); end
    n_cmp++; if (bus.ram_data !== 8'hA5) begin n_err++; $display("FAIL wr_data got %h want a5", bus.ram_data); end
    next_cyc();
    bus.rd_req           = 4'b0100;
    bus.rd_addr[12 +: 6] = 6'h10;
    #1;
    n_cmp++; if (bus.rd_gnt !== 4'b0100) begin n_err++; $display("FAIL wrrd_rd_gnt got %b want 0100", bus.rd_gnt); end
    n_cmp++; if (bus.ram_wren !== 1'b0) begin n_err++; $display("FAIL wrrd_wren_drop got %b want 0", bus.ram_wren); end
    next_cyc();
    bus.rd_req = 4'b0000;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL wrrd_early_valid got %b want 0", bus.rd_valid); end
    next_cyc(); #1;
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL wrrd_valid got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_id !== 2'd2) begin n_err++; $display("FAIL wrrd_id got %0d want 2", bus.rd_id); end
    n_cmp++; if (bus.rd_data !== 8'hA5) begin n_err++; $display("FAIL wrrd_data got %h want a5", bus.rd_data); end
  endtask

  task automatic test_collision();
    logic [7:0] exp_d;
`ifdef WR_BYPASS_EN
    exp_d = 8'h22;
`else
    exp_d = 8'h11;
`endif
    next_cyc();
    bus.wr_req          = 2'b01;
    bus.wr_addr[0 +: 6] = 6'h05;
    bus.wr_data[0 +: 8] = 8'h11;
    next_cyc();
    bus.wr_req = 2'b00;
    next_cyc();
    bus.wr_req          = 2'b01;
    bus.wr_data[0 +: 8] = 8'h22;
    bus.rd_req          = 4'b0010;
    bus.rd_addr[6 +: 6] = 6'h05;
    #1;
    n_cmp++; if (bus.wr_gnt !== 2'b01) begin n_err++; $display("FAIL col_wr_gnt got %b want 01", bus.wr_gnt); end
    n_cmp++; if (bus.rd_gnt !== 4'b0010) begin n_err++; $display("FAIL col_rd_gnt got %b want 0010", bus.rd_gnt); end
    next_cyc();
    bus.wr_req = 2'b00;
    bus.rd_req = 4'b0000;
    next_cyc(); #1;
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL col_valid got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_id !== 2'd1) begin n_err++; $display("FAIL col_id got %0d want 1", bus.rd_id); end
    n_cmp++; if (bus.rd_data !== exp_d) begin n_err++; $display("FAIL col_data got %h want %h", bus.rd_data, exp_d); end
    next_cyc();
    bus.rd_req = 4'b0010;
    next_cyc();
    bus.rd_req = 4'b0000;
    next_cyc(); #1;
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL col_after_valid got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 8'h22) begin n_err++; $display("FAIL col_after_data got %h want 22", bus.rd_data); end
  endtask

  task automatic test_reset_midflight();
    next_cyc();
    bus.rd_req = 4'b1000;
    #1;
    n_cmp++; if (bus.rd_gnt !== 4'b1000) begin n_err++; $display("FAIL mid_gnt got %b want 1000", bus.rd_gnt); end
    next_cyc();
    rst_n      = 1'b0;
    bus.rd_req = 4'b0000;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_c1 got %b want 0", bus.rd_valid); end
    next_cyc();
    rst_n      = 1'b1;
    bus.rd_req = 4'b1111;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_c2 got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_gnt !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got %b want 0001", bus.rd_gnt); end
    next_cyc();
    bus.rd_req = 4'b0000;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_c3 got %b want 0", bus.rd_valid); end
    next_cyc(); next_cyc();
  endtask

  task automatic test_writer_fairness();
    logic [1:0] exp_g;
    logic       exp_w;
    logic [5:0] exp_a;
    logic [7:0] exp_dat;
    bus.wr_addr[0 +: 6] = 6'h20;
    bus.wr_data[0 +: 8] = 8'h30;
    bus.wr_addr[6 +: 6] = 6'h21;
    bus.wr_data[8 +: 8] = 8'h31;
    for (int c = 0; c < 6; c++) begin
      next_cyc();
      bus.wr_req = (c < 4) ? 2'b11 : 2'b00;
      #1;
      exp_g = (c < 4) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_w = (c >= 1) && (c <= 4);
      n_cmp++; if (bus.wr_gnt !== exp_g) begin n_err++; $display("FAIL fair_gnt c=%0d got %b want %b", c, bus.wr_gnt, exp_g); end
      n_cmp++; if (bus.ram_wren !== exp_w) begin n_err++; $display("FAIL fair_wren c=%0d got %b want %b", c, bus.ram_wren, exp_w); end
      if (exp_w) begin
        exp_a   = ((c - 1) % 2 == 1) ? 6'h21 : 6'h20;
        exp_dat = ((c - 1) % 2 == 1) ? 8'h31 : 8'h30;
        n_cmp++; if (bus.ram_wraddress !== exp_a) begin n_err++; $display("FAIL fair_addr c=%0d got %h want %h", c, bus.ram_wraddress, exp_a); end
        n_cmp++; if (bus.ram_data !== exp_dat) begin n_err++; $display("FAIL fair_data c=%0d got %h want %h", c, bus.ram_data, exp_dat); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_round_robin();
    test_write_read();
    test_collision();
    test_reset_midflight();
    test_writer_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
